phy_link_ctrl: RTL and testbench

PHY_LINK_CTRL -- requirements
Module: phy_link_ctrl

---
 rtl/phy_link_ctrl_if.sv | 31 +++
 rtl/phy_link_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_phy_link_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/phy_link_ctrl_if.sv
// Upper-layer payload handshake and p2s transmitter bus of phy_link_ctrl.
// master = upper layer / driver, slave = the link controller.
interface phy_link_ctrl_if;
  logic       IN_ENB;
  logic [7:0] IN_LANE3;
  logic [7:0] IN_LANE2;
  logic [7:0] IN_LANE1;
  logic [7:0] IN_LANE0;
  logic       IN_VALID;
  logic       OUT_READY;
  logic [7:0] OUT_LANE3;
  logic [7:0] OUT_LANE2;
  logic [7:0] OUT_LANE1;
  logic [7:0] OUT_LANE0;
  logic [2:0] OUT_CTR;
  logic       OUT_ENB;
  logic       OUT_VALID;
  logic       OUT_LINK_UP;

  modport master (
    output IN_ENB, IN_LANE3, IN_LANE2, IN_LANE1, IN_LANE0, IN_VALID,
    input  OUT_READY, OUT_LANE3, OUT_LANE2, OUT_LANE1, OUT_LANE0,
    input  OUT_CTR, OUT_ENB, OUT_VALID, OUT_LINK_UP
  );

  modport slave (
    input  IN_ENB, IN_LANE3, IN_LANE2, IN_LANE1, IN_LANE0, IN_VALID,
    output OUT_READY, OUT_LANE3, OUT_LANE2, OUT_LANE1, OUT_LANE0,
    output OUT_CTR, OUT_ENB, OUT_VALID, OUT_LINK_UP
  );
endinterface

// File: rtl/phy_link_ctrl.sv
// Four-lane PHY link controller: training, idle/data framing and periodic SKP insertion.
// Optional SKP insertion enabled by defining PHY_LINK_SKP_EN.
module phy_link_ctrl #(
  parameter int TRAIN_LEN    = 16,
  parameter int SKP_INTERVAL = 64
) (
  input  logic           IN_CLK_250KHz,
  input  logic           IN_RESET,
  phy_link_ctrl_if.slave bus
);

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_TRAIN = 3'd1;
  localparam logic [2:0] ST_IDLE  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_SKP   = 3'd4;

  localparam logic [2:0] CTR_DATA = 3'b000;
  localparam logic [2:0] CTR_COM  = 3'b001;
  localparam logic [2:0] CTR_SKP  = 3'b010;
  localparam logic [2:0] CTR_IDLE = 3'b011;
  localparam logic [2:0] CTR_TS   = 3'b100;

  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_LEN - 1);

  if (TRAIN_LEN < 2 || TRAIN_LEN > 255) begin : g_bad_train_len
    $error("phy_link_ctrl: TRAIN_LEN out of range 2..255");
  end
  if (SKP_INTERVAL < 8 || SKP_INTERVAL > 255) begin : g_bad_skp_interval
    $error("phy_link_ctrl: SKP_INTERVAL out of range 8..255");
  end

  logic [2:0] r_state;
  logic [7:0] r_train_cnt;
  logic [1:0] r_skp_phase;
  logic [7:0] r_lane3, r_lane2, r_lane1, r_lane0;
  logic [2:0] r_ctr;
  logic       r_enb, r_valid, r_ready, r_link_up;

  logic [2:0] w_nxt_state;
  logic [7:0] w_nxt_train;
  logic [1:0] w_nxt_phase;
  logic [7:0] w_nxt_lane3, w_nxt_lane2, w_nxt_lane1, w_nxt_lane0;
  logic [2:0] w_nxt_ctr;
  logic       w_nxt_enb, w_nxt_valid, w_nxt_ready, w_nxt_link_up;
  logic       w_xfer;
  logic       w_skp_hit;
  logic       w_nxt_skp_hit;

  assign w_xfer = bus.IN_VALID & r_ready;

`ifdef PHY_LINK_SKP_EN
  localparam logic [7:0] SKP_LAST = 8'(SKP_INTERVAL - 1);

  logic [7:0] r_skp_cnt;
  logic [7:0] w_nxt_skp;

  // Counter runs only while staying in IDLE/DATA; any other path restarts it at 0.
  always_comb begin
    w_nxt_skp = 8'd0;
    if ((r_state == ST_IDLE || r_state == ST_DATA) &&
        (w_nxt_state == ST_IDLE || w_nxt_state == ST_DATA)) begin
      w_nxt_skp = r_skp_cnt + 8'd1;
    end else begin
      w_nxt_skp = 8'd0;
    end
  end

  assign w_skp_hit     = (r_skp_cnt == SKP_LAST);
  assign w_nxt_skp_hit = (w_nxt_skp == SKP_LAST);

  // SKP interval counter register.
  always_ff @(posedge IN_CLK_250KHz) begin
    if (IN_RESET) begin
      r_skp_cnt <= 8'd0;
    end else begin
      r_skp_cnt <= w_nxt_skp;
    end
  end
`else
  assign w_skp_hit     = 1'b0;
  assign w_nxt_skp_hit = 1'b0;
`endif

  // Next-state logic; dropping IN_ENB wins over everything but reset.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_train = r_train_cnt;
    w_nxt_phase = r_skp_phase;
    if (!bus.IN_ENB) begin
      w_nxt_state = ST_OFF;
      w_nxt_train = 8'd0;
      w_nxt_phase = 2'd0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_nxt_state = ST_TRAIN;
          w_nxt_train = 8'd0;
        end
        ST_TRAIN: begin
          if (r_train_cnt == TRAIN_LAST) begin
            w_nxt_state = ST_IDLE;
            w_nxt_train = 8'd0;
          end else begin
            w_nxt_train = r_train_cnt + 8'd1;
          end
        end
        ST_IDLE, ST_DATA: begin
          if (w_skp_hit) begin
            w_nxt_state = ST_SKP;
            w_nxt_phase = 2'd0;
          end else if (w_xfer) begin
            w_nxt_state = ST_DATA;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end
        ST_SKP: begin
          if (r_skp_phase == 2'd3) begin
            w_nxt_state = ST_IDLE;
            w_nxt_phase = 2'd0;
          end else begin
            w_nxt_phase = r_skp_phase + 2'd1;
          end
        end
        default: begin
          w_nxt_state = ST_OFF;
          w_nxt_train = 8'd0;
          w_nxt_phase = 2'd0;
        end
      endcase
    end
  end

  // Output values for the upcoming state, so every output comes straight from a flop.
  always_comb begin
    w_nxt_lane3   = 8'h00;
    w_nxt_lane2   = 8'h00;
    w_nxt_lane1   = 8'h00;
    w_nxt_lane0   = 8'h00;
    w_nxt_ctr     = CTR_IDLE;
    w_nxt_enb     = 1'b0;
    w_nxt_valid   = 1'b0;
    w_nxt_ready   = 1'b0;
    w_nxt_link_up = 1'b0;
    case (w_nxt_state)
      ST_OFF: begin
        w_nxt_ctr = CTR_IDLE;
      end
      ST_TRAIN: begin
        w_nxt_enb = 1'b1;
        if (w_nxt_train == 8'd0) begin
          {w_nxt_lane3, w_nxt_lane2, w_nxt_lane1, w_nxt_lane0} = {4{8'hBC}};
          w_nxt_ctr = CTR_COM;
        end else begin
          {w_nxt_lane3, w_nxt_lane2, w_nxt_lane1, w_nxt_lane0} = {4{8'h4A}};
          w_nxt_ctr = CTR_TS;
        end
      end
      ST_IDLE: begin
        w_nxt_enb     = 1'b1;
        w_nxt_link_up = 1'b1;
        w_nxt_ready   = ~w_nxt_skp_hit;
      end
      ST_DATA: begin
        w_nxt_lane3   = bus.IN_LANE3;
        w_nxt_lane2   = bus.IN_LANE2;
        w_nxt_lane1   = bus.IN_LANE1;
        w_nxt_lane0   = bus.IN_LANE0;
        w_nxt_ctr     = CTR_DATA;
        w_nxt_enb     = 1'b1;
        w_nxt_valid   = 1'b1;
        w_nxt_link_up = 1'b1;
        w_nxt_ready   = ~w_nxt_skp_hit;
      end
      ST_SKP: begin
        w_nxt_enb     = 1'b1;
        w_nxt_link_up = 1'b1;
        if (w_nxt_phase == 2'd0) begin
          {w_nxt_lane3, w_nxt_lane2, w_nxt_lane1, w_nxt_lane0} = {4{8'hBC}};
          w_nxt_ctr = CTR_COM;
        end else begin
          {w_nxt_lane3, w_nxt_lane2, w_nxt_lane1, w_nxt_lane0} = {4{8'h1C}};
          w_nxt_ctr = CTR_SKP;
        end
      end
      default: begin
        w_nxt_ctr = CTR_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge IN_CLK_250KHz) begin
    if (IN_RESET) begin
      r_state     <= ST_OFF;
      r_train_cnt <= 8'd0;
      r_skp_phase <= 2'd0;
      r_lane3     <= 8'h00;
      r_lane2     <= 8'h00;
      r_lane1     <= 8'h00;
      r_lane0     <= 8'h00;
      r_ctr       <= CTR_IDLE;
      r_enb       <= 1'b0;
      r_valid     <= 1'b0;
      r_ready     <= 1'b0;
      r_link_up   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_train_cnt <= w_nxt_train;
      r_skp_phase <= w_nxt_phase;
      r_lane3     <= w_nxt_lane3;
      r_lane2     <= w_nxt_lane2;
      r_lane1     <= w_nxt_lane1;
      r_lane0     <= w_nxt_lane0;
      r_ctr       <= w_nxt_ctr;
      r_enb       <= w_nxt_enb;
      r_valid     <= w_nxt_valid;
      r_ready     <= w_nxt_ready;
      r_link_up   <= w_nxt_link_up;
    end
  end

  assign bus.OUT_LANE3   = r_lane3;
  assign bus.OUT_LANE2   = r_lane2;
  assign bus.OUT_LANE1   = r_lane1;
  assign bus.OUT_LANE0   = r_lane0;
  assign bus.OUT_CTR     = r_ctr;
  assign bus.OUT_ENB     = r_enb;
  assign bus.OUT_VALID   = r_valid;
  assign bus.OUT_READY   = r_ready;
  assign bus.OUT_LINK_UP = r_link_up;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed bench for phy_link_ctrl with a payload scoreboard queue.
// SKP-specific expectations follow the PHY_LINK_SKP_EN build macro.
module tb_phy_link_ctrl;

  localparam int TRAIN_LEN    = 16;
  localparam int SKP_INTERVAL = 64;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];

  phy_link_ctrl_if bus ();

  phy_link_ctrl #(
    .TRAIN_LEN   (TRAIN_LEN),
    .SKP_INTERVAL(SKP_INTERVAL)
  ) dut (
    .IN_CLK_250KHz(clk),
    .IN_RESET     (rst),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lanes_out();
    return {bus.OUT_LANE3, bus.OUT_LANE2, bus.OUT_LANE1, bus.OUT_LANE0};
  endfunction

  task automatic chk_off(input string tag);
    chk({tag, "_lanes"}, lanes_out(), 32'h0000_0000);
    chk({tag, "_ctr"}, {29'd0, bus.OUT_CTR}, 32'd3);
    chk({tag, "_flags"}, {28'd0, bus.OUT_ENB, bus.OUT_VALID, bus.OUT_READY, bus.OUT_LINK_UP}, 32'd0);
  endtask

  // From an OFF cycle with IN_ENB about to be sampled high: full training, then IDLE.
  task automatic train_up();
    bus.IN_ENB   = 1'b1;
    bus.IN_VALID = 1'b0;
    tick();
    chk("train_com_lanes", lanes_out(), 32'hBCBC_BCBC);
    chk("train_com_ctr", {29'd0, bus.OUT_CTR}, 32'd1);
    chk("train_flags", {28'd0, bus.OUT_ENB, bus.OUT_VALID, bus.OUT_READY, bus.OUT_LINK_UP}, 32'b1000);
    for (int i = 1; i < TRAIN_LEN; i++) begin
      tick();
      chk("train_ts_lanes", lanes_out(), 32'h4A4A_4A4A);
      chk("train_ts_ctr", {29'd0, bus.OUT_CTR}, 32'd4);
    end
    tick();
    chk("idle_lanes", lanes_out(), 32'h0000_0000);
    chk("idle_ctr", {29'd0, bus.OUT_CTR}, 32'd3);
    chk("idle_flags", {28'd0, bus.OUT_ENB, bus.OUT_VALID, bus.OUT_READY, bus.OUT_LINK_UP}, 32'b1011);
  endtask

  // One cycle of payload offer; expected word is queued only if the controller is ready.
  task automatic cycle_data(input logic v, input logic [31:0] word);
    logic        pushed;
    logic [31:0] exp_w;
    bus.IN_VALID = v;
    {bus.IN_LANE3, bus.IN_LANE2, bus.IN_LANE1, bus.IN_LANE0} = word;
    pushed = v && (bus.OUT_READY === 1'b1);
    if (pushed) exp_q.push_back(word);
    tick();
    chk("valid_latency", {31'd0, bus.OUT_VALID}, {31'd0, pushed});
    if (pushed && exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      chk("data_lanes", lanes_out(), exp_w);
      chk("data_ctr", {29'd0, bus.OUT_CTR}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] word;
    int          skp_idx;
    int          drops;
    int          last_drop;
    logic        found;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.IN_ENB   = 1'b1;
    bus.IN_VALID = 1'b1;
    {bus.IN_LANE3, bus.IN_LANE2, bus.IN_LANE1, bus.IN_LANE0} = 32'h5555_5555;
    for (int i = 0; i < 3; i++) tick();
    chk_off("reset");

    // Release reset: one OFF cycle, then training.
    rst = 1'b0;
    train_up();

    // Three back-to-back words, then return to IDLE.
    word = 32'h4433_2211;
    for (int i = 0; i < 3; i++) begin
      cycle_data(1'b1, word);
      word = word + 32'h0101_0101;
    end
    cycle_data(1'b0, word);
    chk("idle_after_data_ctr", {29'd0, bus.OUT_CTR}, 32'd3);

    // Long stream with IN_VALID held high.
    skp_idx   = -1;
    drops     = 0;
    last_drop = -1;
`ifdef PHY_LINK_SKP_EN
    for (int c = 0; c < 200; c++) begin
      cycle_data(1'b1, word);
      word = word + 32'h0101_0101;
      if (skp_idx >= 0) begin
        chk("skp_lanes", lanes_out(), (skp_idx == 0) ? 32'hBCBC_BCBC : 32'h1C1C_1C1C);
        chk("skp_ctr", {29'd0, bus.OUT_CTR}, (skp_idx == 0) ? 32'd1 : 32'd2);
        skp_idx = (skp_idx == 3) ? -1 : skp_idx + 1;
      end else if (bus.OUT_READY === 1'b0) begin
        drops++;
        if (last_drop >= 0) chk("skp_period", c - last_drop, SKP_INTERVAL + 4);
        last_drop = c;
        skp_idx   = 0;
      end
    end
    chk("skp_drops_ge2", {31'd0, drops >= 2}, 32'd1);
`else
    for (int c = 0; c < 300; c++) begin
      cycle_data(1'b1, word);
      word = word + 32'h0101_0101;
      chk("ready_held", {31'd0, bus.OUT_READY}, 32'd1);
      chk("no_skp_ctr", {31'd0, bus.OUT_CTR == 3'b010}, 32'd0);
    end
`endif
    cycle_data(1'b0, word);
    chk("stream_q_empty", exp_q.size(), 32'd0);

    // Drop IN_ENB from IDLE, retrain, then abort at training cycle 5.
    bus.IN_ENB = 1'b0;
    tick();
    chk_off("idle_abort");
    bus.IN_ENB = 1'b1;
    tick();
    chk("retrain_com", lanes_out(), 32'hBCBC_BCBC);
    for (int i = 1; i <= 5; i++) tick();
    chk("train5_ctr", {29'd0, bus.OUT_CTR}, 32'd4);
    bus.IN_ENB = 1'b0;
    tick();
    chk_off("train_abort");
    train_up();

`ifdef PHY_LINK_SKP_EN
    // Wait for an SKP burst and abort at its cycle 2.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      found = (bus.OUT_CTR === 3'b001) && (bus.OUT_LINK_UP === 1'b1);
    end
    chk("skp_found", {31'd0, found}, 32'd1);
    tick();
    tick();
    chk("skp2_ctr", {29'd0, bus.OUT_CTR}, 32'd2);
    bus.IN_ENB = 1'b0;
    tick();
    chk_off("skp_abort");
    train_up();
`endif

    // Reset while a transfer is in flight drops the word.
    word = 32'hA1B2_C3D4;
    cycle_data(1'b1, word);
    bus.IN_VALID = 1'b1;
    rst = 1'b1;
    tick();
    chk_off("reset_mid_data");
    chk("reset_q_empty", exp_q.size(), 32'd0);
    rst = 1'b0;
    bus.IN_VALID = 1'b0;
    train_up();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
